keypad_debounce_ctrl: RTL and testbench

Parametrised keypad debouncer and event generator. It sits between the raw keypad encoder (code + press flag) and the operand-entry logic.
- Synchronises the raw inputs and debounces both press and release.
- Emits exactly one press event per debounced keystroke through a valid/ready output register.
- Reports the current held key and flags any events lost to back-pressure.

---
 rtl/keypad_debounce_ctrl.sv | 177 +++++++++++++++++
 tb/tb_keypad_debounce_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce_ctrl.sv
// Keypad debouncer: 2-flop sync, press/release debounce, one-entry valid/ready event register.
// Optional auto-repeat when KEY_DEBOUNCE_REPEAT_EN is defined; otherwise out_repeat is tied to 0.
module keypad_debounce_ctrl #(
    parameter int KEY_W         = 4,
    parameter int DEB_CYCLES    = 16,
    parameter int CNT_W         = $clog2(DEB_CYCLES),
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_press_in,
    input  logic [KEY_W-1:0] key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] out_key,
    output logic             out_repeat,
    output logic             key_held,
    output logic [KEY_W-1:0] held_key,
    input  logic             ovf_clr,
    output logic             ovf
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
    localparam logic [1:0] ST_HELD       = 2'd2;
    localparam logic [1:0] ST_REL_WAIT   = 2'd3;

    logic [1:0]       state;
    logic             press_s1;
    logic             s_press;
    logic [KEY_W-1:0] key_s1;
    logic [KEY_W-1:0] s_key;
    logic [KEY_W-1:0] cand;
    logic [CNT_W-1:0] cnt;
    logic             match;
    logic             cnt_done;
    logic             push_press;
    logic             push_rep;
    logic             push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_s1 <= 1'b0;
            s_press  <= 1'b0;
            key_s1   <= '0;
            s_key    <= '0;
        end else begin
            press_s1 <= key_press_in;
            s_press  <= press_s1;
            key_s1   <= key_in;
            s_key    <= key_s1;
        end
    end

    assign match      = s_press && (s_key == cand);
    assign cnt_done   = (cnt == CNT_W'(DEB_CYCLES - 1));
    assign push_press = (state == ST_PRESS_WAIT) && match && cnt_done;
    assign push       = push_press || push_rep;
    assign key_held   = (state == ST_HELD) || (state == ST_REL_WAIT);
    assign held_key   = key_held ? cand : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_press) begin
                        cand  <= s_key;
                        cnt   <= '0;
                        state <= ST_PRESS_WAIT;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s_press) begin
                        state <= ST_IDLE;
                    end else if (s_key != cand) begin
                        cand <= s_key;
                        cnt  <= '0;
                    end else if (cnt_done) begin
                        state <= ST_HELD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!match) begin
                        cnt   <= '0;
                        state <= ST_REL_WAIT;
                    end
                end
                ST_REL_WAIT: begin
                    // A different key here counts toward release, not as a new press.
                    if (match) begin
                        state <= ST_HELD;
                    end else if (cnt_done) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W = (RMAX > 2) ? $clog2(RMAX) : 1;

    logic [RCNT_W-1:0] rcnt;
    logic              rep_phase;
    logic              rep_hit;
    logic              rep_q;

    assign rep_hit    = rep_phase ? (rcnt == RCNT_W'(REPEAT_PERIOD - 1))
                                  : (rcnt == RCNT_W'(REPEAT_DELAY - 1));
    assign push_rep   = (state == ST_HELD) && match && rep_hit;
    assign out_repeat = rep_q;

    // rcnt only advances on matching HELD cycles, so it pauses across release bounces.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
        end else if (push_press) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
        end else if ((state == ST_HELD) && match) begin
            if (rep_hit) begin
                rcnt      <= '0;
                rep_phase <= 1'b1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q <= 1'b0;
        end else if (push && (!out_valid || out_ready)) begin
            rep_q <= push_rep;
        end
    end
`else
    assign push_rep   = 1'b0;
    assign out_repeat = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_key   <= '0;
        end else if (push && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            out_key   <= cand;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A drop in the same cycle as ovf_clr leaves ovf set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (push && out_valid && !out_ready) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_debounce_ctrl.sv
// Bench for keypad_debounce_ctrl: directed scenarios plus randomized stimulus against a run-length model.
module tb_keypad_debounce_ctrl;
    localparam int KEY_W = 4;
    localparam int DEB   = 4;
    localparam int RDEL  = 8;
    localparam int RPER  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             key_press_in = 1'b0;
    logic [KEY_W-1:0] key_in = '0;
    logic             out_ready = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             out_valid;
    logic [KEY_W-1:0] out_key;
    logic             out_repeat;
    logic             key_held;
    logic [KEY_W-1:0] held_key;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    keypad_debounce_ctrl #(
        .KEY_W(KEY_W), .DEB_CYCLES(DEB), .REPEAT_DELAY(RDEL), .REPEAT_PERIOD(RPER)
    ) dut (
        .clk(clk), .rst(rst), .key_press_in(key_press_in), .key_in(key_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key),
        .out_repeat(out_repeat), .key_held(key_held), .held_key(held_key),
        .ovf_clr(ovf_clr), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference model: inputs delayed two samples, then debounced by counting
    // run lengths of identical samples (DEB+1 in a row accepts a press or release).
    logic             mp1 = 0, mp2 = 0;
    logic [KEY_W-1:0] mk1 = 0, mk2 = 0, m_rkey = 0, m_hk = 0, m_key = 0;
    int               m_run = 0, m_r = 0;
    bit               m_held = 0, m_phase = 0, m_valid = 0, m_rep = 0, m_ovf = 0;

    initial begin : model
        bit               ev, evrep, drop;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mp1 = 0; mp2 = 0; mk1 = 0; mk2 = 0; m_rkey = 0; m_hk = 0; m_key = 0;
                m_run = 0; m_r = 0; m_held = 0; m_phase = 0; m_valid = 0; m_rep = 0; m_ovf = 0;
            end else begin
                ev = 0; evrep = 0;
                if (!m_held) begin
                    if (mp2) begin
                        if (m_run > 0 && mk2 == m_rkey) m_run++;
                        else begin m_run = 1; m_rkey = mk2; end
                    end else m_run = 0;
                    if (m_run == DEB + 1) begin
                        ev = 1; m_held = 1; m_hk = m_rkey; m_run = 0; m_r = 0; m_phase = 0;
                    end
                end else if (mp2 && mk2 == m_hk) begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
                    if (m_run == 0) begin
                        m_r++;
                        if (m_r == (m_phase ? RPER : RDEL)) begin
                            ev = 1; evrep = 1; m_r = 0; m_phase = 1;
                        end
                    end
`endif
                    m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == DEB + 1) begin m_held = 0; m_run = 0; end
                end
                drop = ev && m_valid && !out_ready;
                if (ev && !drop) begin m_valid = 1; m_key = m_hk; m_rep = evrep; end
                else if (m_valid && out_ready) m_valid = 0;
                if (drop) m_ovf = 1;
                else if (ovf_clr) m_ovf = 0;
                mp2 = mp1; mp1 = key_press_in; mk2 = mk1; mk1 = key_in;
            end
        end
    end

    task automatic idle_settle;
        @(negedge clk);
        key_press_in = 0; out_ready = 1; ovf_clr = 1;
        repeat (14) @(negedge clk);
        ovf_clr = 0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({out_valid, out_key, out_repeat, key_held, held_key, ovf} !== 12'h0) begin
            errors++; $display("FAIL reset_async: got %h want 000", {out_valid, out_key, out_repeat, key_held, held_key, ovf});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_key, out_repeat, key_held, held_key, ovf} !== 12'h0) begin
            errors++; $display("FAIL reset_clocked: got %h want 000", {out_valid, out_key, out_repeat, key_held, held_key, ovf});
        end
        rst = 0;
    endtask

    task automatic test_clean_press;
        int nv = 0;
        idle_settle();
        key_in = 4'h7; key_press_in = 1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (e == 6) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL press_early: out_valid=%b want 0 at edge 6", out_valid); end
            end
            if (e == 7) begin
                checks++;
                if (out_valid !== 1'b1 || out_key !== 4'h7) begin
                    errors++; $display("FAIL press_edge7: out_valid=%b out_key=%h want 1/7", out_valid, out_key);
                end
            end
            if (out_valid && !out_repeat) nv++;
        end
        checks++;
        if (nv != 1) begin errors++; $display("FAIL press_count: got %0d events want 1", nv); end
        checks++;
        if (key_held !== 1'b1 || held_key !== 4'h7) begin
            errors++; $display("FAIL press_held: key_held=%b held_key=%h want 1/7", key_held, held_key);
        end
        @(negedge clk); key_press_in = 0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            if (e == 6 || e == 7) begin
                checks++;
                if (key_held !== (e == 6)) begin
                    errors++; $display("FAIL release_edge%0d: key_held=%b want %b", e, key_held, e == 6);
                end
            end
        end
    endtask

    task automatic test_bounce;
        int nv = 0;
        idle_settle();
        key_in = 4'h3;
        for (int i = 0; i < 12; i++) begin
            key_press_in = ((i / 2) % 2 == 0);
            @(negedge clk);
            if (out_valid) nv++;
        end
        checks++;
        if (nv != 0) begin errors++; $display("FAIL bounce_quiet: got %0d valid cycles want 0", nv); end
        key_press_in = 1;
        for (int e = 1; e <= 17; e++) begin
            @(posedge clk); #1;
            if (e == 6) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL bounce_early: out_valid=%b want 0", out_valid); end
            end
            if (e == 7) begin
                checks++;
                if (out_valid !== 1'b1 || out_key !== 4'h3) begin
                    errors++; $display("FAIL bounce_edge7: out_valid=%b out_key=%h want 1/3", out_valid, out_key);
                end
            end
            if (out_valid && !out_repeat) nv++;
        end
        checks++;
        if (nv != 1) begin errors++; $display("FAIL bounce_count: got %0d events want 1", nv); end
    endtask

    task automatic test_release_bounce;
        int bad = 0;
        idle_settle();
        key_in = 4'h5; key_press_in = 1;
        repeat (12) @(negedge clk);
        checks++;
        if (key_held !== 1'b1 || held_key !== 4'h5) begin
            errors++; $display("FAIL relb_held: key_held=%b held_key=%h want 1/5", key_held, held_key);
        end
        key_press_in = 0;
        repeat (2) @(negedge clk);
        key_press_in = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (!key_held || (out_valid && !out_repeat)) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL relb_stable: got %0d bad cycles want 0", bad); end
        key_press_in = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (key_held !== 1'b0) begin errors++; $display("FAIL relb_release: key_held=%b want 0", key_held); end
    endtask

    task automatic test_back_pressure;
        idle_settle();
        out_ready = 0; key_in = 4'h1; key_press_in = 1;
        repeat (10) @(negedge clk);
        key_press_in = 0;
        repeat (10) @(negedge clk);
        key_in = 4'h2; key_press_in = 1;
        repeat (10) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_key !== 4'h1 || ovf !== 1'b1) begin
            errors++; $display("FAIL bp_hold: valid=%b key=%h ovf=%b want 1/1/1", out_valid, out_key, ovf);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        checks++;
        if (out_valid !== 1'b0 || ovf !== 1'b1) begin
            errors++; $display("FAIL bp_pop: valid=%b ovf=%b want 0/1", out_valid, ovf);
        end
        ovf_clr = 1;
        @(negedge clk);
        ovf_clr = 0;
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_clr: ovf=%b want 0", ovf); end
    endtask

    task automatic test_reset_mid_debounce;
        idle_settle();
        key_in = 4'hA; key_press_in = 1;
        @(posedge clk); @(posedge clk); #2;
        rst = 1; #1;
        checks++;
        if ({out_valid, out_key, out_repeat, key_held, held_key, ovf} !== 12'h0) begin
            errors++; $display("FAIL rst_mid: got %h want 000", {out_valid, out_key, out_repeat, key_held, held_key, ovf});
        end
        repeat (2) @(negedge clk);
        rst = 0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            if (e == 6 || e == 7) begin
                checks++;
                if (out_valid !== (e == 7) || (e == 7 && out_key !== 4'hA)) begin
                    errors++; $display("FAIL rst_recover_edge%0d: valid=%b key=%h want %b/a", e, out_valid, out_key, e == 7);
                end
            end
        end
    endtask

`ifdef KEY_DEBOUNCE_REPEAT_EN
    task automatic test_repeat;
        int t = 0, exp_t = RDEL, nrep = 0, late = 0;
        bit seen = 0;
        idle_settle();
        key_in = 4'h9; key_press_in = 1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            seen = out_valid && !out_repeat;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rep_first: no press event within 20 cycles"); end
        for (t = 1; t <= 30; t++) begin
            @(posedge clk); #1;
            if (out_valid && out_repeat) begin
                checks++;
                if (t != exp_t || out_key !== 4'h9) begin
                    errors++; $display("FAIL rep_time: got +%0d key %h want +%0d key 9", t, out_key, exp_t);
                end
                exp_t += RPER; nrep++;
            end
        end
        checks++;
        if (nrep != 6) begin errors++; $display("FAIL rep_count: got %0d want 6", nrep); end
        @(negedge clk); key_press_in = 0;
        for (int i = 0; i < 20 && key_held; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (out_valid) late++; end
        checks++;
        if (key_held !== 1'b0 || late != 0) begin
            errors++; $display("FAIL rep_after_release: key_held=%b late events=%0d want 0/0", key_held, late);
        end
    endtask
`endif

    task automatic test_random(input int ncyc);
        int seg = 0;
        logic [11:0] expv;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            expv = {m_valid, m_key, m_rep, m_held, (m_held ? m_hk : 4'h0), m_ovf};
            checks++;
            if ({out_valid, out_key, out_repeat, key_held, held_key, ovf} !== expv) begin
                errors++;
                $display("FAIL random cyc %0d: got %b want %b", i,
                         {out_valid, out_key, out_repeat, key_held, held_key, ovf}, expv);
            end
            if (seg == 0) begin
                key_press_in = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 2) == 0) key_in = 4'($urandom_range(0, 15));
                seg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
            end
            seg--;
            out_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_back_pressure();
        test_reset_mid_debounce();
`ifdef KEY_DEBOUNCE_REPEAT_EN
        test_repeat();
`endif
        test_random(4000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
